// File: rtl/param_stack.sv
// LIFO stack with registered pop data, sticky overflow/underflow flags and same-edge push+pop replace.
// Define PARAM_STACK_HWM_EN to track the high-water mark on hwm; otherwise hwm is tied to 0.
module param_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic [WIDTH-1:0]             data_in,
   input  logic                         err_clr,
   output logic [WIDTH-1:0]             data_out,
   output logic                         out_valid,
   output logic [WIDTH-1:0]             top,
   output logic [$clog2(DEPTH):0]       count,
   output logic                         full,
   output logic                         empty,
   output logic                         error,
   output logic [1:0]                   err_code,
   output logic [$clog2(DEPTH):0]       hwm
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0]   ONE_C    = 1;
   localparam logic [AW-1:0] ONE_A    = 1;

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             out_valid_q, out_valid_d;
   logic [1:0]       err_q, err_d;
   logic [AW-1:0]    top_idx, wr_idx;
   logic             wr_en, ovf, unf;

   assign full     = (count_q == FULL_CNT);
   assign empty    = (count_q == '0);
   // When full the low AW bits are zero, so the subtraction wraps to DEPTH-1 as intended.
   assign top_idx  = count_q[AW-1:0] - ONE_A;
   assign top      = empty ? '0 : mem[top_idx];
   assign count    = count_q;
   assign data_out = data_out_q;
   assign out_valid = out_valid_q;
   assign err_code = err_q;
   assign error    = |err_q;

   always_comb begin
      count_d     = count_q;
      data_out_d  = data_out_q;
      out_valid_d = 1'b0;
      wr_en       = 1'b0;
      wr_idx      = count_q[AW-1:0];
      ovf         = 1'b0;
      unf         = 1'b0;
      case ({push, pop})
         2'b10: begin
            if (full) begin
               ovf = 1'b1;
            end else begin
               wr_en   = 1'b1;
               count_d = count_q + ONE_C;
            end
         end
         2'b01: begin
            if (empty) begin
               unf = 1'b1;
            end else begin
               data_out_d  = mem[top_idx];
               out_valid_d = 1'b1;
               count_d     = count_q - ONE_C;
            end
         end
         2'b11: begin
            out_valid_d = 1'b1;
            if (empty) begin
               data_out_d = data_in;
            end else begin
               data_out_d = mem[top_idx];
               wr_en      = 1'b1;
               wr_idx     = top_idx;
            end
         end
         default: ;
      endcase
      // A fresh error on the clearing edge still lands.
      err_d = (err_clr ? 2'b00 : err_q) | {unf, ovf};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q     <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 2'b00;
      end else begin
         count_q     <= count_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         mem[wr_idx] <= data_in;
      end
   end

`ifdef PARAM_STACK_HWM_EN
   logic [AW:0] hwm_q, hwm_d;

   assign hwm_d = (count_d > hwm_q) ? count_d : hwm_q;
   assign hwm   = hwm_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         hwm_q <= '0;
      end else begin
         hwm_q <= hwm_d;
      end
   end
`else
   assign hwm = '0;
`endif

endmodule
